wb_dbg_master: RTL and testbench
================================

WB_DBG_MASTER -- requirements
Module: wb_dbg_master

Interface
REQ-001 Parameter bus_timeout, default 1023: max cycles a Wishbone cycle may stay open before abort.
REQ-002 Parameter rx_timeout, default 500000: max idle cycles between command bytes before the parser resyncs.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_dat  input  8  received byte from the UART core.
REQ-006 rx_stb  input  1  one-cycle pulse, rx_dat valid.
REQ-007 tx_dat  output  8  byte to transmit.
REQ-008 tx_stb  output  1  one-cycle pulse, start transmit of tx_dat.
REQ-009 tx_busy  input  1  UART transmitter busy.
REQ-010 wb_adr_o  output  32  Wishbone master address, bits [1:0] always 0.
REQ-011 wb_dat_o / wb_dat_i  output/input  32  write / read data.
REQ-012 wb_sel_o  output  4  constant 4'hF.
REQ-013 wb_we_o, wb_cyc_o, wb_stb_o  output  1 each  Wishbone master controls.
REQ-014 wb_ack_i, wb_err_i, wb_rty_i  input  1 each  Wishbone slave terminations.

Function
REQ-015 Protocol: opcode 0x01 = write (4 address bytes MSB first, then 4 data bytes MSB first); opcode 0x02 = read (4 address bytes MSB first).
REQ-016 FSM states IDLE, ADDR, DATA, BUS, RESP; IDLE->ADDR on a valid opcode byte; any other byte in IDLE is discarded, state stays IDLE.
REQ-017 ADDR: 4 bytes, then DATA for write or BUS for read; DATA: 4 bytes then BUS.
REQ-018 wb_cyc_o and wb_stb_o assert together on the cycle after the last command byte is accepted, and stay high until termination.
REQ-019 Termination is the first cycle with ack, err or rty high; cyc/stb/we drop on the next edge.
REQ-020 Read data is captured on the cycle wb_ack_i is high.
REQ-021 Bus timer counts cycles with cyc high; reaching bus_timeout terminates the cycle as an error.
REQ-022 Status byte: 0xA5 on ack; 0xEE on err, rty or timeout.
REQ-023 Response: write = status only; read = status then 4 data bytes MSB first; read data bytes are 0x00 on error.
REQ-024 RESP: tx_stb pulses only when tx_busy=0; the next byte is not strobed until at least one cycle after the previous strobe and tx_busy=0 again.
REQ-025 After the last response byte is strobed, return to IDLE.
REQ-026 In ADDR/DATA, an idle gap of rx_timeout cycles without rx_stb returns to IDLE and discards the partial command, with no bus cycle and no response.
REQ-027 rx_stb during BUS or RESP is ignored, with no buffering.
REQ-028 wb_dat_o and wb_adr_o are stable for the whole cycle.

Reset
REQ-029 On reset: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, tx_stb = 0; wb_adr_o, wb_dat_o, tx_dat = 0; counters cleared.
REQ-030 Reset during BUS drops cyc/stb on the next edge; no response byte is sent.

Structure
REQ-031 Package wb_dbg_pkg holds the opcodes (0x01, 0x02), status codes (0xA5, 0xEE) and the FSM state enum.
REQ-032 Single module; no sub-module; one shared byte counter serves ADDR, DATA and RESP.

Verification
REQ-033 Write: 01 00 00 10 04 DE AD BE EF, slave acks in 2 cycles -> one write cycle, adr 0x00001004, dat 0xDEADBEEF, we=1, response A5.
REQ-034 Read: 02 40 00 00 08, slave returns 0x12345678 with ack -> response A5 12 34 56 78, each byte strobed only while tx_busy=0.
REQ-035 Read from an unmapped address with no ack, bus_timeout=16 -> cyc held exactly 16 cycles, response EE 00 00 00 00.
REQ-036 Bytes 02 40 then a gap exceeding rx_timeout, then 7F, then a full write -> 7F discarded, only the write executes, response A5.
REQ-037 wb_err_i on a write -> response EE; reset asserted mid BUS -> cyc low next edge, no tx_stb, next command served normally.

Source files
------------

// File: rtl/wb_dbg_pkg.sv
// Shared constants for the UART-driven Wishbone debug master:
// command opcodes, response status codes and the command FSM states.
package wb_dbg_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;

    localparam logic [7:0] STATUS_ACK = 8'hA5;
    localparam logic [7:0] STATUS_ERR = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/wb_dbg_master.sv
// Byte-stream debug bridge: parses read/write commands from a UART receiver,
// runs one Wishbone classic cycle and streams the status/read data back.
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int unsigned bus_timeout = 1023,
    parameter int unsigned rx_timeout  = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_dat,
    input  logic        rx_stb,
    output logic [7:0]  tx_dat,
    output logic        tx_stb,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    localparam int BT_W = $clog2(bus_timeout + 1);
    localparam int RT_W = $clog2(rx_timeout + 1);

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic            is_wr_reg, is_wr_next;
    logic [31:0]     adr_reg, adr_next;
    logic [31:0]     wdat_reg, wdat_next;
    logic [31:0]     rdat_reg, rdat_next;
    logic [7:0]      status_reg, status_next;
    logic [BT_W-1:0] bus_tmr_reg, bus_tmr_next;
    logic [RT_W-1:0] rx_tmr_reg, rx_tmr_next;
    logic            cyc_reg, cyc_next;
    logic            we_reg, we_next;
    logic            tx_stb_reg, tx_stb_next;
    logic [7:0]      tx_dat_reg, tx_dat_next;

    logic            bus_timed_out;
    logic            bus_term;
    logic            rx_idle_expired;
    logic            last_resp;
    logic [7:0]      resp_byte;

    assign bus_timed_out   = (bus_tmr_reg == BT_W'(bus_timeout - 1));
    assign bus_term        = wb_ack_i | wb_err_i | wb_rty_i | bus_timed_out;
    assign rx_idle_expired = (rx_tmr_reg == RT_W'(rx_timeout - 1));
    assign last_resp       = is_wr_reg ? (cnt_reg == 3'd0) : (cnt_reg == 3'd4);

    // Byte 0 of every response is the status, then read data MSB first.
    always_comb begin
        resp_byte = status_reg;
        case (cnt_reg)
            3'd1:    resp_byte = rdat_reg[31:24];
            3'd2:    resp_byte = rdat_reg[23:16];
            3'd3:    resp_byte = rdat_reg[15:8];
            3'd4:    resp_byte = rdat_reg[7:0];
            default: resp_byte = status_reg;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        is_wr_next   = is_wr_reg;
        adr_next     = adr_reg;
        wdat_next    = wdat_reg;
        rdat_next    = rdat_reg;
        status_next  = status_reg;
        bus_tmr_next = bus_tmr_reg;
        rx_tmr_next  = rx_tmr_reg;
        cyc_next     = cyc_reg;
        we_next      = we_reg;
        tx_stb_next  = 1'b0;
        tx_dat_next  = tx_dat_reg;

        case (state_reg)
            ST_IDLE: begin
                if (rx_stb && (rx_dat == OP_WRITE || rx_dat == OP_READ)) begin
                    is_wr_next  = (rx_dat == OP_WRITE);
                    cnt_next    = 3'd0;
                    rx_tmr_next = '0;
                    state_next  = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (rx_stb) begin
                    adr_next    = {adr_reg[23:0], rx_dat};
                    rx_tmr_next = '0;
                    if (cnt_reg == 3'd3) begin
                        cnt_next = 3'd0;
                        if (is_wr_reg) begin
                            state_next = ST_DATA;
                        end else begin
                            state_next   = ST_BUS;
                            cyc_next     = 1'b1;
                            we_next      = 1'b0;
                            bus_tmr_next = '0;
                        end
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end else if (rx_idle_expired) begin
                    state_next = ST_IDLE;
                end else begin
                    rx_tmr_next = rx_tmr_reg + 1'b1;
                end
            end

            ST_DATA: begin
                if (rx_stb) begin
                    wdat_next   = {wdat_reg[23:0], rx_dat};
                    rx_tmr_next = '0;
                    if (cnt_reg == 3'd3) begin
                        cnt_next     = 3'd0;
                        state_next   = ST_BUS;
                        cyc_next     = 1'b1;
                        we_next      = 1'b1;
                        bus_tmr_next = '0;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end else if (rx_idle_expired) begin
                    state_next = ST_IDLE;
                end else begin
                    rx_tmr_next = rx_tmr_reg + 1'b1;
                end
            end

            ST_BUS: begin
                if (bus_term) begin
                    cyc_next    = 1'b0;
                    we_next     = 1'b0;
                    cnt_next    = 3'd0;
                    state_next  = ST_RESP;
                    // A simultaneous ack wins over err/rty/timeout.
                    status_next = wb_ack_i ? STATUS_ACK : STATUS_ERR;
                    rdat_next   = wb_ack_i ? wb_dat_i : 32'h0;
                end else begin
                    bus_tmr_next = bus_tmr_reg + 1'b1;
                end
            end

            ST_RESP: begin
                // The strobe register itself enforces a gap cycle between bytes.
                if (!tx_busy && !tx_stb_reg) begin
                    tx_stb_next = 1'b1;
                    tx_dat_next = resp_byte;
                    if (last_resp) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 3'd0;
            is_wr_reg   <= 1'b0;
            adr_reg     <= 32'h0;
            wdat_reg    <= 32'h0;
            rdat_reg    <= 32'h0;
            status_reg  <= 8'h0;
            bus_tmr_reg <= '0;
            rx_tmr_reg  <= '0;
            cyc_reg     <= 1'b0;
            we_reg      <= 1'b0;
            tx_stb_reg  <= 1'b0;
            tx_dat_reg  <= 8'h0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            is_wr_reg   <= is_wr_next;
            adr_reg     <= adr_next;
            wdat_reg    <= wdat_next;
            rdat_reg    <= rdat_next;
            status_reg  <= status_next;
            bus_tmr_reg <= bus_tmr_next;
            rx_tmr_reg  <= rx_tmr_next;
            cyc_reg     <= cyc_next;
            we_reg      <= we_next;
            tx_stb_reg  <= tx_stb_next;
            tx_dat_reg  <= tx_dat_next;
        end
    end

    assign wb_adr_o = adr_reg & 32'hFFFF_FFFC;
    assign wb_dat_o = wdat_reg;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = we_reg;
    assign wb_cyc_o = cyc_reg;
    assign wb_stb_o = cyc_reg;
    assign tx_stb   = tx_stb_reg;
    assign tx_dat   = tx_dat_reg;

endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed bench for wb_dbg_master: drives command bytes, models a Wishbone
// slave and a UART transmitter, and scoreboards the response byte stream.
module tb_wb_dbg_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_dat;
    logic        rx_stb;
    logic [7:0]  tx_dat;
    logic        tx_stb;
    logic        tx_busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    wb_dbg_master #(
        .bus_timeout(16),
        .rx_timeout (50)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_dat  (rx_dat),
        .rx_stb  (rx_stb),
        .tx_dat  (tx_dat),
        .tx_stb  (tx_stb),
        .tx_busy (tx_busy),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o),
        .wb_we_o (wb_we_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];

    // slave behaviour: 0 = never respond, 1 = ack, 2 = err, 3 = rty
    int          slv_mode  = 0;
    int          slv_delay = 1;
    logic [31:0] slv_rdata = 32'h0;
    int          cyc_cnt   = 0;
    int          last_cyc_len = 0;
    int          n_bus     = 0;
    logic [31:0] cap_adr   = 32'h0;
    logic [31:0] cap_dat   = 32'h0;
    logic        cap_we    = 1'b0;
    int          busy_cnt  = 0;
    int          n_tx      = 0;
    int          b0;
    int          t0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample DUT at the falling edge, update the UART and slave models.
    task automatic tick();
        @(negedge clk);
        if (tx_stb) begin
            n_tx++;
            check("tx_while_busy", 32'(tx_busy), 32'h0);
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL tx_unexpected: observed byte %h expected no byte", tx_dat);
            end
            if (exp_q.size() != 0) check("tx_byte", 32'(tx_dat), 32'(exp_q.pop_front()));
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = (busy_cnt != 0);

        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_dat_i = 32'hBAD0_BAD0;
        if (wb_cyc_o) begin
            cyc_cnt++;
            check("stb_with_cyc", 32'(wb_stb_o), 32'h1);
            check("sel", 32'(wb_sel_o), 32'hF);
            if (cyc_cnt == 1) begin
                cap_adr = wb_adr_o;
                cap_dat = wb_dat_o;
                cap_we  = wb_we_o;
            end else begin
                check("adr_stable", wb_adr_o, cap_adr);
                check("dat_stable", wb_dat_o, cap_dat);
            end
            if (cyc_cnt == slv_delay) begin
                case (slv_mode)
                    1: begin wb_ack_i = 1'b1; wb_dat_i = slv_rdata; end
                    2: wb_err_i = 1'b1;
                    3: wb_rty_i = 1'b1;
                    default: ;
                endcase
            end
        end else begin
            if (cyc_cnt != 0) begin
                last_cyc_len = cyc_cnt;
                n_bus++;
            end
            cyc_cnt = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dat = b;
        rx_stb = 1'b1;
        tick();
        rx_stb = 1'b0;
        rx_dat = 8'h00;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat);
        send_byte(op);
        for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
        if (op == 8'h01) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
        check("cyc_after_last_byte", 32'(wb_cyc_o), 32'h1);
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || wb_cyc_o || cyc_cnt != 0) && i < budget) begin
            tick();
            i++;
        end
        check("wait_in_budget", 32'(i < budget), 32'h1);
        for (int k = 0; k < 8; k++) tick();
        check("resp_all_sent", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_dat   = 8'h00;
        rx_stb   = 1'b0;
        tx_busy  = 1'b0;
        wb_dat_i = 32'h0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        tick();
        check("rst_tx_stb", 32'(tx_stb), 32'h0);
        check("rst_tx_dat", 32'(tx_dat), 32'h0);
        check("rst_cyc", 32'(wb_cyc_o), 32'h0);
        check("rst_stb", 32'(wb_stb_o), 32'h0);
        check("rst_we", 32'(wb_we_o), 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);

        // write acked after 2 cycles
        b0 = n_bus; slv_mode = 1; slv_delay = 2;
        exp_q.push_back(8'hA5);
        send_cmd(8'h01, 32'h0000_1004, 32'hDEAD_BEEF);
        wait_done(200);
        check("wr_bus_count", 32'(n_bus - b0), 32'h1);
        check("wr_adr", cap_adr, 32'h0000_1004);
        check("wr_dat", cap_dat, 32'hDEAD_BEEF);
        check("wr_we", 32'(cap_we), 32'h1);
        check("wr_cyc_len", 32'(last_cyc_len), 32'h2);

        // read acked with data
        b0 = n_bus; slv_mode = 1; slv_delay = 3; slv_rdata = 32'h1234_5678;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        exp_q.push_back(8'h56); exp_q.push_back(8'h78);
        send_cmd(8'h02, 32'h4000_0008, 32'h0);
        wait_done(300);
        check("rd_bus_count", 32'(n_bus - b0), 32'h1);
        check("rd_adr", cap_adr, 32'h4000_0008);
        check("rd_we", 32'(cap_we), 32'h0);
        check("rd_cyc_len", 32'(last_cyc_len), 32'h3);

        // read with no slave response: bus timeout
        slv_mode = 0;
        exp_q.push_back(8'hEE); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_cmd(8'h02, 32'hF000_0000, 32'h0);
        wait_done(300);
        check("timeout_cyc_len", 32'(last_cyc_len), 32'd16);

        // partial command, rx idle gap, stray byte, then a full write
        b0 = n_bus;
        send_byte(8'h02);
        send_byte(8'h40);
        for (int i = 0; i < 60; i++) tick();
        send_byte(8'h7F);
        for (int i = 0; i < 4; i++) tick();
        check("resync_no_bus", 32'(n_bus - b0), 32'h0);
        check("resync_cyc_low", 32'(wb_cyc_o), 32'h0);
        slv_mode = 1; slv_delay = 1;
        exp_q.push_back(8'hA5);
        send_cmd(8'h01, 32'h0000_0020, 32'h0BAD_F00D);
        wait_done(200);
        check("resync_bus_count", 32'(n_bus - b0), 32'h1);
        check("resync_adr", cap_adr, 32'h0000_0020);
        check("resync_dat", cap_dat, 32'h0BAD_F00D);

        // write terminated by err
        slv_mode = 2; slv_delay = 1;
        exp_q.push_back(8'hEE);
        send_cmd(8'h01, 32'h0000_0104, 32'h1122_3344);
        wait_done(200);
        check("err_we", 32'(cap_we), 32'h1);

        // read terminated by rty on an unaligned address
        slv_mode = 3; slv_delay = 2;
        exp_q.push_back(8'hEE); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        send_cmd(8'h02, 32'h0000_0107, 32'h0);
        wait_done(300);
        check("rty_adr_aligned", cap_adr, 32'h0000_0104);

        // reset in the middle of a bus cycle
        slv_mode = 0;
        send_cmd(8'h02, 32'h0000_2000, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        t0 = n_tx;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_bus_cyc", 32'(wb_cyc_o), 32'h0);
        check("rst_bus_stb", 32'(wb_stb_o), 32'h0);
        for (int i = 0; i < 30; i++) tick();
        check("rst_bus_no_tx", 32'(n_tx - t0), 32'h0);

        // normal service after the reset
        b0 = n_bus; slv_mode = 1; slv_delay = 1; slv_rdata = 32'hCAFE_F00D;
        exp_q.push_back(8'hA5); exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
        send_cmd(8'h02, 32'h0000_3000, 32'h0);
        wait_done(300);
        check("post_rst_bus_count", 32'(n_bus - b0), 32'h1);
        check("post_rst_adr", cap_adr, 32'h0000_3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
